// File: rtl/convolve.sv
// Sequential 40-point convolution y[n] = extract_h(L_shl(sum x[i]*h[n-i], 3)) driving
// external saturating arithmetic units and a one-cycle-latency word memory.
module convolve #(
  parameter logic [11:0] X_BASE = 12'h000,
  parameter logic [11:0] H_BASE = 12'h040,
  parameter logic [11:0] Y_BASE = 12'h080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic [11:0] memReadAddr,
  input  logic [31:0] memIn,
  output logic [11:0] memWriteAddr,
  output logic [31:0] memOut,
  output logic        memWriteEn,
  output logic [15:0] L_macOutA,
  output logic [15:0] L_macOutB,
  output logic [31:0] L_macOutC,
  input  logic [31:0] L_macIn,
  output logic [31:0] L_shlVar1Out,
  output logic [15:0] L_shlNumShiftOut,
  output logic        L_shlReady,
  input  logic [31:0] L_shlIn,
  input  logic        L_shlDone,
  output logic [15:0] addOutA,
  output logic [15:0] addOutB,
  input  logic [15:0] addIn,
  output logic [15:0] subOutA,
  output logic [15:0] subOutB,
  input  logic [15:0] subIn
);

  localparam logic [3:0] INIT     = 4'd0;
  localparam logic [3:0] N_CHK    = 4'd1;
  localparam logic [3:0] I_CHK    = 4'd2;
  localparam logic [3:0] RD_H     = 4'd3;
  localparam logic [3:0] MAC      = 4'd4;
  localparam logic [3:0] SHL      = 4'd5;
  localparam logic [3:0] SHL_WAIT = 4'd6;
  localparam logic [3:0] WR       = 4'd7;
  localparam logic [3:0] DONE     = 4'd8;

  localparam logic [15:0] N_POINTS = 16'd40;

  logic [3:0]  state_r;
  logic [15:0] n_r;
  logic [15:0] i_r;
  logic [31:0] s_r;
  logic [15:0] xv_r;
  logic [31:0] t_r;

  // Bits deliberately ignored: upper halves of 16-bit memory words, high index bits, low half of t.
  logic unused_s;
  assign unused_s = ^{memIn[31:16], subIn[15:6], t_r[15:0]};

  // State machine and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= INIT;
      n_r     <= 16'd0;
      i_r     <= 16'd0;
      s_r     <= 32'd0;
      xv_r    <= 16'd0;
      t_r     <= 32'd0;
    end else begin
      case (state_r)
        INIT: begin
          if (start) begin
            n_r     <= 16'd0;
            i_r     <= 16'd0;
            s_r     <= 32'd0;
            xv_r    <= 16'd0;
            t_r     <= 32'd0;
            state_r <= N_CHK;
          end else begin
            state_r <= INIT;
          end
        end
        N_CHK: begin
          if (n_r >= N_POINTS) begin
            state_r <= DONE;
          end else begin
            s_r     <= 32'd0;
            i_r     <= 16'd0;
            state_r <= I_CHK;
          end
        end
        I_CHK: begin
          if (i_r > n_r) begin
            state_r <= SHL;
          end else begin
            state_r <= RD_H;
          end
        end
        RD_H: begin
          xv_r    <= memIn[15:0];
          state_r <= MAC;
        end
        MAC: begin
          s_r     <= L_macIn;
          i_r     <= addIn;
          state_r <= I_CHK;
        end
        SHL, SHL_WAIT: begin
          // The shifter may answer in its request cycle; otherwise park until it does.
          if (L_shlDone) begin
            t_r     <= L_shlIn;
            state_r <= WR;
          end else begin
            state_r <= SHL_WAIT;
          end
        end
        WR: begin
          n_r     <= addIn;
          state_r <= N_CHK;
        end
        DONE: begin
          state_r <= INIT;
        end
        default: begin
          state_r <= INIT;
        end
      endcase
    end
  end

  // Output decode: every port is zero unless the current state uses it.
  always_comb begin
    done             = 1'b0;
    memReadAddr      = 12'h000;
    memWriteAddr     = 12'h000;
    memOut           = 32'h0000_0000;
    memWriteEn       = 1'b0;
    L_macOutA        = 16'h0000;
    L_macOutB        = 16'h0000;
    L_macOutC        = 32'h0000_0000;
    L_shlVar1Out     = 32'h0000_0000;
    L_shlNumShiftOut = 16'h0000;
    L_shlReady       = 1'b0;
    addOutA          = 16'h0000;
    addOutB          = 16'h0000;
    subOutA          = 16'h0000;
    subOutB          = 16'h0000;
    case (state_r)
      I_CHK: begin
        if (i_r <= n_r) begin
          memReadAddr = {X_BASE[11:6], i_r[5:0]};
        end else begin
          memReadAddr = 12'h000;
        end
      end
      RD_H: begin
        subOutA     = n_r;
        subOutB     = i_r;
        memReadAddr = {H_BASE[11:6], subIn[5:0]};
      end
      MAC: begin
        L_macOutA = xv_r;
        L_macOutB = memIn[15:0];
        L_macOutC = s_r;
        addOutA   = i_r;
        addOutB   = 16'd1;
      end
      SHL: begin
        L_shlVar1Out     = s_r;
        L_shlNumShiftOut = 16'd3;
        L_shlReady       = 1'b1;
      end
      SHL_WAIT: begin
        L_shlVar1Out     = s_r;
        L_shlNumShiftOut = 16'd3;
        L_shlReady       = 1'b0;
      end
      WR: begin
        memWriteAddr = {Y_BASE[11:6], n_r[5:0]};
        memOut       = {16'h0000, t_r[31:16]};
        memWriteEn   = 1'b1;
        addOutA      = n_r;
        addOutB      = 16'd1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_convolve.sv
// Scoreboard bench for convolve: directed x/h vectors with hand-computed y words and done cycles;
// models the memory, saturating L_mac/L_shl and add/sub units around the DUT.
module tb_convolve;

  localparam logic [11:0] XB = 12'h100;
  localparam logic [11:0] HB = 12'h240;
  localparam logic [11:0] YB = 12'h3C0;

  logic        clk;
  logic        reset;
  logic        start;
  logic        done;
  logic [11:0] memReadAddr;
  logic [31:0] memIn;
  logic [11:0] memWriteAddr;
  logic [31:0] memOut;
  logic        memWriteEn;
  logic [15:0] L_macOutA, L_macOutB;
  logic [31:0] L_macOutC, L_macIn;
  logic [31:0] L_shlVar1Out, L_shlIn;
  logic [15:0] L_shlNumShiftOut;
  logic        L_shlReady, L_shlDone;
  logic [15:0] addOutA, addOutB, addIn;
  logic [15:0] subOutA, subOutB, subIn;

  logic [31:0] mem [0:4095];
  logic        shl_delay;
  logic        rdy_d1, rdy_d2;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          writes_seen = 0;
  int          dones_seen = 0;
  logic        prev_done = 1'b0;
  logic [43:0] wr_q [$];
  int          done_q [$];

  convolve #(.X_BASE(XB), .H_BASE(HB), .Y_BASE(YB)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .memReadAddr(memReadAddr), .memIn(memIn),
    .memWriteAddr(memWriteAddr), .memOut(memOut), .memWriteEn(memWriteEn),
    .L_macOutA(L_macOutA), .L_macOutB(L_macOutB), .L_macOutC(L_macOutC), .L_macIn(L_macIn),
    .L_shlVar1Out(L_shlVar1Out), .L_shlNumShiftOut(L_shlNumShiftOut), .L_shlReady(L_shlReady),
    .L_shlIn(L_shlIn), .L_shlDone(L_shlDone),
    .addOutA(addOutA), .addOutB(addOutB), .addIn(addIn),
    .subOutA(subOutA), .subOutB(subOutB), .subIn(subIn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Saturating 32-bit accumulate of 2*a*b.
  function automatic logic [31:0] l_mac(logic [15:0] a, logic [15:0] b, logic [31:0] c);
    logic signed [31:0] p;
    logic signed [32:0] sum;
    if (a == 16'h8000 && b == 16'h8000) begin
      p = 32'sh7FFF_FFFF;
    end else begin
      p = $signed(a) * $signed(b);
      p = p <<< 1;
    end
    sum = $signed({c[31], c}) + $signed({p[31], p});
    if (sum[32] != sum[31]) return sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return sum[31:0];
  endfunction

  // Saturating left shift (arithmetic right shift for negative counts).
  function automatic logic [31:0] l_shl(logic [31:0] v, logic [15:0] sh);
    logic signed [31:0] r;
    int k;
    r = $signed(v);
    k = int'($signed(sh));
    if (k < 0) return r >>> ((-k > 31) ? 31 : -k);
    for (int j = 0; j < k; j++) begin
      if (r > 32'sh3FFF_FFFF) return 32'h7FFF_FFFF;
      if (r < $signed(32'hC000_0000)) return 32'h8000_0000;
      r = r <<< 1;
    end
    return r;
  endfunction

  assign L_macIn   = l_mac(L_macOutA, L_macOutB, L_macOutC);
  assign L_shlIn   = l_shl(L_shlVar1Out, L_shlNumShiftOut);
  assign L_shlDone = shl_delay ? rdy_d2 : L_shlReady;
  assign addIn     = addOutA + addOutB;
  assign subIn     = subOutA - subOutB;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rdy_d1 <= L_shlReady;
    rdy_d2 <= rdy_d1;
    memIn  <= mem[memReadAddr];
    if (memWriteEn) mem[memWriteAddr] <= memOut;
  end

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pop expected writes / done cycles whenever the DUT presents them.
  always @(negedge clk) begin
    logic [43:0] e;
    int ed;
    if (memWriteEn) begin
      writes_seen++;
      check(wr_q.size() != 0, "write_expected", {memWriteAddr, memOut}, 44'd0);
      if (wr_q.size() != 0) begin
        e = wr_q.pop_front();
        check({memWriteAddr, memOut} == e, "write_addr_data", {memWriteAddr, memOut}, e);
      end
    end
    if (done) begin
      dones_seen++;
      check(done_q.size() != 0, "done_expected", cyc, 0);
      if (done_q.size() != 0) begin
        ed = done_q.pop_front();
        check(cyc == ed, "done_cycle", cyc, ed);
      end
    end
    if (prev_done) check(done == 1'b0, "done_one_cycle", done, 0);
    prev_done = done;
  end

  // Hand-computed y[n] for each directed pattern.
  function automatic logic [15:0] exp_y(int pat, int n);
    case (pat)
      0: return 16'(n + 1);
      1: return 16'h0000;
      2: return 16'h7FFF;
      default: return (n == 0) ? 16'h8000 : 16'h0000;
    endcase
  endfunction

  task automatic load(input int pat);
    for (int k = 0; k < 64; k++) begin
      mem[XB + 12'(k)] = 32'h0;
      mem[HB + 12'(k)] = 32'h0;
      mem[YB + 12'(k)] = 32'hDEAD_BEEF;
    end
    for (int k = 0; k < 40; k++) begin
      case (pat)
        0: begin mem[HB + 12'(k)] = 32'(k + 1); if (k == 0) mem[XB] = 32'h0000_1000; end
        1: mem[HB + 12'(k)] = 32'(k + 1);
        2: begin mem[XB + 12'(k)] = 32'h0000_7FFF; mem[HB + 12'(k)] = 32'h0000_7FFF; end
        default: if (k == 0) begin mem[XB] = 32'h0000_8000; mem[HB] = 32'h0000_1000; end
      endcase
    end
  endtask

  task automatic push_run(input int pat, input int done_at);
    for (int k = 0; k < 40; k++) wr_q.push_back({YB + 12'(k), 16'h0000, exp_y(pat, k)});
    done_q.push_back(done_at);
  endtask

  task automatic run(input int pat, input int extra);
    @(negedge clk);
    start = 1'b1;
    push_run(pat, cyc + 2622 + 40 * extra);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (done_q.size() != 0 && k < 8000) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check(done_q.size() == 0, "run_timeout", done_q.size(), 0);
    check(wr_q.size() == 0, "write_count_left", wr_q.size(), 0);
  endtask

  initial begin
    int c0, w0, d0;
    reset = 1'b1;
    start = 1'b0;
    shl_delay = 1'b0;
    repeat (3) @(negedge clk);
    check({done, memReadAddr, memWriteAddr, memOut, memWriteEn, L_macOutA, L_macOutB, L_macOutC,
           L_shlVar1Out, L_shlNumShiftOut, L_shlReady, addOutA, addOutB, subOutA, subOutB} == '0,
          "reset_outputs_zero", 64'(memOut), 0);
    reset = 1'b0;

    load(0); run(0, 0); wait_idle();

    // Zero vector with start held through DONE: a second run starts on return to INIT.
    load(1);
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    push_run(1, c0 + 2622);
    push_run(1, c0 + 2623 + 2622);
    repeat (2624) @(negedge clk);
    start = 1'b0;
    wait_idle();

    load(2); run(2, 0); wait_idle();
    load(3); run(3, 0); wait_idle();

    load(0); shl_delay = 1'b1; run(0, 2); wait_idle(); shl_delay = 1'b0;

    // Reset at cycle 100: writes for n=0..5 land first, then the run is abandoned.
    load(0);
    w0 = writes_seen;
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    push_run(0, c0 + 2622);
    @(negedge clk);
    start = 1'b0;
    while (cyc < c0 + 100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check({done, memReadAddr, memWriteEn, L_shlReady, addOutA, subOutA} == '0,
          "mid_run_reset_outputs_zero", {done, memWriteEn, L_shlReady}, 0);
    check(writes_seen - w0 == 6, "writes_before_reset", writes_seen - w0, 6);
    wr_q.delete();
    done_q.delete();
    w0 = writes_seen;
    d0 = dones_seen;
    repeat (3000) @(negedge clk);
    check(writes_seen == w0, "no_writes_after_reset", writes_seen - w0, 0);
    check(dones_seen == d0, "no_done_after_reset", dones_seen - d0, 0);

    load(0); run(0, 0); wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
